// File: rtl/pl_pkg.sv
// Shared definitions for the pipeline execute stage: ALU opcodes, branch funct3
// codes, the ID/EX register layout and the branch-condition decode.
package pl_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        alu_op_e     alu_ctrl;
        logic [2:0]  funct3;
        logic        branch;
        logic        jump;
        logic        jalr;
        logic [31:0] src_a;
        logic [31:0] src_b;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        reg_write;
    } idex_t;

    // Flags come from the a-b subtraction; funct3 010/011 are not branches.
    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                          input logic neg, input logic ovf, input logic ltu);
        logic taken;
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = !zero;
            F3_BLT:  taken = neg ^ ovf;
            F3_BGE:  taken = !(neg ^ ovf);
            F3_BLTU: taken = ltu;
            F3_BGEU: taken = !ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/pl_alu.sv
// Combinational 32-bit ALU. zero/neg/ovf always describe a-b so the branch
// unit can use them whatever operation is selected.
module pl_alu
    import pl_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_e     alu_ctrl,
    output logic [31:0] result,
    output logic        zero,
    output logic        neg,
    output logic        ovf
);

    logic [31:0] diff;

    assign diff = a - b;
    assign zero = (diff == 32'd0);
    assign neg  = diff[31];
    assign ovf  = (a[31] ^ b[31]) & (a[31] ^ diff[31]);

    always_comb begin
        result = 32'd0;
        case (alu_ctrl)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = diff;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << b[4:0];
            ALU_SRL:  result = a >> b[4:0];
            ALU_SRA:  result = $signed(a) >>> b[4:0];
            ALU_SLT:  result = {31'd0, neg ^ ovf};
            ALU_SLTU: result = {31'd0, a < b};
            default:  result = 32'd0;
        endcase
    end

endmodule

// File: rtl/pl_execute_stage.sv
// Execute stage: ID/EX register, ALU and branch/jump resolution, EX/MEM register.
// Every ex_* data output is meaningful only while ex_valid=1; there is no backpressure.
module pl_execute_stage
    import pl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic [3:0]  alu_ctrl,
    input  logic [2:0]  funct3,
    input  logic        branch,
    input  logic        jump,
    input  logic        jalr,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [4:0]  rd,
    input  logic        reg_write,
    output logic        ex_valid,
    output logic [31:0] ex_result,
    output logic [4:0]  ex_rd,
    output logic        ex_reg_write,
    output logic        ex_redirect,
    output logic [31:0] ex_target
);

    idex_t       id_in;
    idex_t       idex;
    logic        idex_valid;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_neg;
    logic        alu_ovf;
    logic        alu_ltu;
    logic        br_cond;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] result;

    assign id_in = '{alu_ctrl:  alu_op_e'(alu_ctrl),
                     funct3:    funct3,
                     branch:    branch,
                     jump:      jump,
                     jalr:      jalr,
                     src_a:     src_a,
                     src_b:     src_b,
                     pc:        pc,
                     imm:       imm,
                     rd:        rd,
                     reg_write: reg_write};

    // Flush beats stall: the held instruction is killed even while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_valid <= 1'b0;
            idex       <= '0;
        end else if (flush) begin
            idex_valid <= 1'b0;
        end else if (!stall) begin
            idex_valid <= id_valid;
            idex       <= id_in;
        end
    end

    pl_alu u_alu (
        .a        (idex.src_a),
        .b        (idex.src_b),
        .alu_ctrl (idex.alu_ctrl),
        .result   (alu_result),
        .zero     (alu_zero),
        .neg      (alu_neg),
        .ovf      (alu_ovf)
    );

    assign alu_ltu  = idex.src_a < idex.src_b;
    assign br_cond  = branch_taken(idex.funct3, alu_zero, alu_neg, alu_ovf, alu_ltu);
    assign redirect = idex_valid & (idex.jump | (idex.branch & br_cond));
    assign target   = (idex.jump & idex.jalr) ? {alu_result[31:1], 1'b0} : idex.pc + idex.imm;
    assign result   = idex.jump ? idex.pc + 32'd4 : alu_result;

    // A stall sends a bubble downstream; data fields keep their old values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_redirect  <= 1'b0;
            ex_result    <= 32'd0;
            ex_target    <= 32'd0;
            ex_rd        <= 5'd0;
        end else if (stall) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_redirect  <= 1'b0;
        end else begin
            ex_valid     <= idex_valid;
            ex_reg_write <= idex_valid & idex.reg_write;
            ex_redirect  <= redirect;
            ex_result    <= result;
            ex_target    <= target;
            ex_rd        <= idex.rd;
        end
    end

endmodule

// File: tb/tb_pl_execute_stage.sv
// Self-checking bench for pl_execute_stage: directed corner cases plus random
// traffic, scored against a plain-arithmetic reference model.
module tb_pl_execute_stage;

    typedef struct packed {
        logic [3:0]  alu_ctrl;
        logic [2:0]  funct3;
        logic        branch;
        logic        jump;
        logic        jalr;
        logic [31:0] src_a;
        logic [31:0] src_b;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        reg_write;
    } instr_t;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] target;
        logic [4:0]  rd;
        logic        reg_write;
        logic        redirect;
        logic        chk_target;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic        stall;
    logic        flush;
    logic [3:0]  alu_ctrl;
    logic [2:0]  funct3;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        reg_write;
    logic        ex_valid;
    logic [31:0] ex_result;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_redirect;
    logic [31:0] ex_target;

    pl_execute_stage dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .stall        (stall),
        .flush        (flush),
        .alu_ctrl     (alu_ctrl),
        .funct3       (funct3),
        .branch       (branch),
        .jump         (jump),
        .jalr         (jalr),
        .src_a        (src_a),
        .src_b        (src_b),
        .pc           (pc),
        .imm          (imm),
        .rd           (rd),
        .reg_write    (reg_write),
        .ex_valid     (ex_valid),
        .ex_result    (ex_result),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .ex_redirect  (ex_redirect),
        .ex_target    (ex_target)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, required finish within 500000 time units");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    exp_t   exp_q[$];
    exp_t   held_exp;
    bit     held_valid;
    exp_t   mon_e;
    int     check_cnt = 0;
    int     fail_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        check_cnt++;
        if (act !== req) begin
            fail_cnt++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic exp_t model(input instr_t t);
        exp_t               e;
        logic [31:0]        a;
        logic [31:0]        b;
        logic [31:0]        alu;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        bit                 taken;
        a  = t.src_a;
        b  = t.src_b;
        sa = a;
        sb = b;
        case (t.alu_ctrl)
            4'd0:    alu = a + b;
            4'd1:    alu = a - b;
            4'd2:    alu = a & b;
            4'd3:    alu = a | b;
            4'd4:    alu = a ^ b;
            4'd5:    alu = a << b[4:0];
            4'd6:    alu = a >> b[4:0];
            4'd7:    alu = sa >>> b[4:0];
            4'd8:    alu = (sa < sb) ? 32'd1 : 32'd0;
            4'd9:    alu = (a < b) ? 32'd1 : 32'd0;
            default: alu = 32'd0;
        endcase
        case (t.funct3)
            3'b000:  taken = (a == b);
            3'b001:  taken = (a != b);
            3'b100:  taken = (sa < sb);
            3'b101:  taken = (sa >= sb);
            3'b110:  taken = (a < b);
            3'b111:  taken = (a >= b);
            default: taken = 1'b0;
        endcase
        e.redirect   = t.jump | (t.branch & taken);
        e.result     = t.jump ? t.pc + 32'd4 : alu;
        e.target     = (t.jump & t.jalr) ? (alu & ~32'd1) : t.pc + t.imm;
        e.rd         = t.rd;
        e.reg_write  = t.reg_write;
        e.chk_target = t.branch | t.jump;
        return e;
    endfunction

    function automatic instr_t mk(input logic [3:0] ctrl, input logic [2:0] f3,
                                  input logic br, input logic jp, input logic jr,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] p, input logic [31:0] im,
                                  input logic [4:0] d, input logic rw);
        instr_t t;
        t = '{alu_ctrl: ctrl, funct3: f3, branch: br, jump: jp, jalr: jr,
              src_a: a, src_b: b, pc: p, imm: im, rd: d, reg_write: rw};
        return t;
    endfunction

    function automatic exp_t mke(input logic [31:0] res, input logic [31:0] tgt,
                                 input logic [4:0] d, input logic rw,
                                 input logic redir, input logic chk);
        exp_t e;
        e = '{result: res, target: tgt, rd: d, reg_write: rw, redirect: redir, chk_target: chk};
        return e;
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        int     k;
        t           = '0;
        t.src_a     = $urandom;
        if ($urandom_range(0, 3) == 0) t.src_a = $urandom_range(0, 16);
        t.src_b     = ($urandom_range(0, 3) == 0) ? t.src_a : $urandom;
        t.pc        = $urandom & 32'hFFFF_FFFC;
        t.imm       = $urandom;
        t.rd        = 5'($urandom_range(0, 31));
        t.reg_write = 1'($urandom_range(0, 1));
        t.funct3    = 3'($urandom_range(0, 7));
        t.alu_ctrl  = 4'($urandom_range(0, 15));
        k = $urandom_range(0, 9);
        if (k >= 6 && k < 8) begin
            t.branch    = 1'b1;
            t.alu_ctrl  = 4'd1;
            t.reg_write = 1'b0;
        end else if (k == 8) begin
            t.jump = 1'b1;
        end else if (k == 9) begin
            t.jump     = 1'b1;
            t.jalr     = 1'b1;
            t.alu_ctrl = 4'd0;
            t.src_b    = t.imm;
        end
        return t;
    endfunction

    // ---------------- driver ----------------
    // Called #1 after a rising edge; the inputs are sampled by the next edge.
    task automatic step(input instr_t t, input exp_t e, input bit v, input bit st, input bit fl);
        id_valid  = v;
        stall     = st;
        flush     = fl;
        alu_ctrl  = t.alu_ctrl;
        funct3    = t.funct3;
        branch    = t.branch;
        jump      = t.jump;
        jalr      = t.jalr;
        src_a     = t.src_a;
        src_b     = t.src_b;
        pc        = t.pc;
        imm       = t.imm;
        rd        = t.rd;
        reg_write = t.reg_write;
        if (!st && held_valid) exp_q.push_back(held_exp);
        if (fl) begin
            held_valid = 1'b0;
        end else if (!st) begin
            held_valid = v;
            held_exp   = e;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (!ex_valid) begin
                check("bubble_reg_write", 32'(ex_reg_write), 32'd0);
                check("bubble_redirect", 32'(ex_redirect), 32'd0);
            end else if (exp_q.size() == 0) begin
                check_cnt++;
                fail_cnt++;
                $display("FAIL unexpected_output: got ex_valid=1 rd=%0d result=%h, required no output",
                         ex_rd, ex_result);
            end else begin
                mon_e = exp_q.pop_front();
                check("ex_result", ex_result, mon_e.result);
                check("ex_rd", 32'(ex_rd), 32'(mon_e.rd));
                check("ex_reg_write", 32'(ex_reg_write), 32'(mon_e.reg_write));
                check("ex_redirect", 32'(ex_redirect), 32'(mon_e.redirect));
                if (mon_e.chk_target) check("ex_target", ex_target, mon_e.target);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        instr_t t;
        bit     v;
        bit     st;
        bit     fl;
        held_valid = 1'b0;
        held_exp   = '0;
        rst        = 1'b0;
        id_valid   = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;
        alu_ctrl   = '0;
        funct3     = '0;
        branch     = 1'b0;
        jump       = 1'b0;
        jalr       = 1'b0;
        src_a      = '0;
        src_b      = '0;
        pc         = '0;
        imm        = '0;
        rd         = '0;
        reg_write  = 1'b0;

        #2 rst = 1'b1;
        #1;
        check("reset_ex_valid", 32'(ex_valid), 32'd0);
        check("reset_ex_reg_write", 32'(ex_reg_write), 32'd0);
        check("reset_ex_redirect", 32'(ex_redirect), 32'd0);
        check("reset_ex_result", ex_result, 32'd0);
        check("reset_ex_target", ex_target, 32'd0);
        check("reset_ex_rd", 32'(ex_rd), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Directed cases with hand-computed expectations.
        step(mk(4'b0000, 3'b000, 0, 0, 0, 32'd5, 32'd7, 32'h0, 32'h0, 5'd3, 1),
             mke(32'd12, 32'h0, 5'd3, 1, 0, 0), 1, 0, 0);
        step(mk(4'b0111, 3'b000, 0, 0, 0, 32'h8000_0000, 32'd4, 32'h0, 32'h0, 5'd4, 1),
             mke(32'hF800_0000, 32'h0, 5'd4, 1, 0, 0), 1, 0, 0);
        step(mk(4'b0110, 3'b000, 0, 0, 0, 32'h8000_0000, 32'd4, 32'h0, 32'h0, 5'd5, 1),
             mke(32'h0800_0000, 32'h0, 5'd5, 1, 0, 0), 1, 0, 0);
        step(mk(4'b0001, 3'b100, 1, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 5'd0, 0),
             mke(32'hFFFF_FFFE, 32'h120, 5'd0, 0, 1, 1), 1, 0, 0);
        step(mk(4'b0001, 3'b110, 1, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 5'd0, 0),
             mke(32'hFFFF_FFFE, 32'h120, 5'd0, 0, 0, 1), 1, 0, 0);
        step(mk(4'b0000, 3'b000, 0, 1, 1, 32'h1001, 32'd4, 32'h40, 32'd4, 5'd1, 1),
             mke(32'h44, 32'h1004, 5'd1, 1, 1, 1), 1, 0, 0);
        step(mk(4'b1000, 3'b000, 0, 0, 0, 32'h8000_0000, 32'd1, 32'h0, 32'h0, 5'd6, 1),
             mke(32'd1, 32'h0, 5'd6, 1, 0, 0), 1, 0, 0);
        step(mk(4'b1001, 3'b000, 0, 0, 0, 32'h8000_0000, 32'd1, 32'h0, 32'h0, 5'd7, 1),
             mke(32'd0, 32'h0, 5'd7, 1, 0, 0), 1, 0, 0);
        step(mk(4'b1010, 3'b000, 0, 0, 0, 32'h1234_5678, 32'd1, 32'h0, 32'h0, 5'd8, 1),
             mke(32'd0, 32'h0, 5'd8, 1, 0, 0), 1, 0, 0);
        step(mk(4'b0000, 3'b000, 0, 0, 0, 32'hFFFF_FFFF, 32'd2, 32'h0, 32'h0, 5'd9, 1),
             mke(32'd1, 32'h0, 5'd9, 1, 0, 0), 1, 0, 0);
        step(mk(4'b0001, 3'b010, 1, 0, 0, 32'd1, 32'd2, 32'h200, 32'h8, 5'd0, 0),
             mke(32'hFFFF_FFFF, 32'h208, 5'd0, 0, 0, 1), 1, 0, 0);
        idle(3);

        // Stall held three cycles: three bubbles, then the instruction once.
        step(mk(4'b0010, 3'b000, 0, 0, 0, 32'hF0F0, 32'hFF00, 32'h0, 32'h0, 5'd10, 1),
             mke(32'hF000, 32'h0, 5'd10, 1, 0, 0), 1, 0, 0);
        repeat (3) step('0, '0, 1'b1, 1'b1, 1'b0);
        idle(3);

        // Stall together with flush: the held instruction never emerges.
        step(mk(4'b0011, 3'b000, 0, 0, 0, 32'h0F, 32'hF0, 32'h0, 32'h0, 5'd11, 1),
             mke(32'hFF, 32'h0, 5'd11, 1, 0, 0), 1, 0, 0);
        step('0, '0, 1'b1, 1'b1, 1'b1);
        idle(3);

        // Asynchronous reset while a jump is on the outputs.
        step(mk(4'b0000, 3'b000, 0, 1, 0, 32'h0, 32'h0, 32'h300, 32'h40, 5'd12, 1),
             mke(32'h304, 32'h340, 5'd12, 1, 1, 1), 1, 0, 0);
        step('0, '0, 1'b0, 1'b0, 1'b0);
        check("pre_reset_ex_redirect", 32'(ex_redirect), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("async_reset_ex_valid", 32'(ex_valid), 32'd0);
        check("async_reset_ex_redirect", 32'(ex_redirect), 32'd0);
        check("async_reset_ex_reg_write", 32'(ex_reg_write), 32'd0);
        check("async_reset_ex_target", ex_target, 32'd0);
        exp_q.delete();
        held_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Random traffic with random stalls and flushes.
        for (int n = 0; n < 400; n++) begin
            t  = rand_instr();
            v  = ($urandom_range(0, 9) < 8);
            st = ($urandom_range(0, 9) < 2);
            fl = ($urandom_range(0, 9) == 0);
            step(t, model(t), v, st, fl);
        end
        idle(4);
        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", check_cnt, fail_cnt);
        $finish;
    end

endmodule
